sonic_ring_ctrl: RTL and testbench

Occupancy and flow controller for one circular buffer of 0x3E00 entries. It sits directly upstream of the read/write address calculator: it accepts burst deposits from the producer (DMA side) and grants per-entry consumes. Its `cons_ena` output is the calculator's combined `incr`/`ena` qualifier. It mirrors the same modulo-DEPTH pointers, so occupancy, empty/full and back-pressure are exact.

---
 rtl/sonic_ring_ctrl.sv | 130 +++++++++++++
 tb/tb_sonic_ring_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sonic_ring_ctrl.sv
// Occupancy and flow controller for one circular buffer; grants per-entry consumes and back-pressures burst deposits.
// Optional statistics counters are built when SONIC_RING_STATS_EN is defined.
module sonic_ring_ctrl #(
  parameter int DEPTH = 15872,
  parameter int AW    = 14,
  parameter int CW    = 15,
  parameter int MAXB  = 512,
  parameter int LO_WM = 512
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          enable,
  input  logic          flush,
  input  logic          prod_valid,
  input  logic [9:0]    prod_count,
  output logic          prod_ready,
  input  logic          cons_req,
  output logic          cons_ena,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [CW-1:0] occupancy,
  output logic          empty,
  output logic          full,
  output logic [1:0]    state,
  output logic          underrun,
  output logic          proto_err,
  output logic [31:0]   underrun_cnt,
  output logic [31:0]   grant_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  // Modulo-DEPTH pointer advance; n never exceeds MAXB so one subtraction suffices.
  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] p, input logic [9:0] n);
    logic [AW:0] s;
    s = {1'b0, p} + (AW+1)'(n);
    if (s >= (AW+1)'(DEPTH))
      s = s - (AW+1)'(DEPTH);
    return AW'(s);
  endfunction

  logic          offer_take;
  logic          count_bad;
  logic          accepted;
  logic          run_underrun;
  logic [CW:0]   occ_sum;
  logic [1:0]    state_nxt;

  assign empty      = (occupancy == '0);
  assign full       = (occupancy == CW'(DEPTH));
  assign prod_ready = (occupancy <= CW'(DEPTH - MAXB)) && (state != S_IDLE) && !flush;
  assign cons_ena   = cons_req && (state == S_RUN) && !empty && !flush;

  assign offer_take   = prod_valid && prod_ready;
  assign count_bad    = (prod_count > 10'(MAXB));
  assign accepted     = offer_take && !count_bad && (prod_count != 10'd0);
  assign run_underrun = enable && (state == S_RUN) && cons_req && empty;

  assign occ_sum = {1'b0, occupancy}
                 + (accepted ? (CW+1)'(prod_count) : '0)
                 - (CW+1)'(cons_ena);

  always_comb begin
    state_nxt = state;
    if (!enable)
      state_nxt = S_IDLE;
    else begin
      case (state)
        S_IDLE:  state_nxt = S_FILL;
        S_FILL:  if ((occupancy >= CW'(LO_WM)) || full) state_nxt = S_RUN;
        S_RUN:   if (run_underrun) state_nxt = S_FILL;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      state     <= S_IDLE;
      underrun  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (accepted)
        wr_ptr <= wrap_add(wr_ptr, prod_count);
      if (cons_ena)
        rd_ptr <= wrap_add(rd_ptr, 10'd1);
      // Top bit only sets on a wrap below zero, which the grant qualifier rules out.
      if (!occ_sum[CW])
        occupancy <= CW'(occ_sum);
      if (offer_take && count_bad)
        proto_err <= 1'b1;
      if (run_underrun)
        underrun <= 1'b1;
      state <= state_nxt;
    end
  end

`ifdef SONIC_RING_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] grant_q;
  logic [31:0] urun_q;

  always_ff @(posedge clk_in) begin
    if (reset || flush) begin
      grant_q <= '0;
      urun_q  <= '0;
    end else begin
      if (cons_ena)
        grant_q <= sat_inc(grant_q);
      if (run_underrun)
        urun_q <= sat_inc(urun_q);
    end
  end

  assign grant_cnt    = grant_q;
  assign underrun_cnt = urun_q;
`else
  assign grant_cnt    = '0;
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_sonic_ring_ctrl.sv
// Directed bench for sonic_ring_ctrl: prefill, full/ready boundaries, wrap, underrun, protocol error, idle and flush.
module tb_sonic_ring_ctrl;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic        prod_valid = 1'b0;
  logic [9:0]  prod_count = 10'd0;
  logic        prod_ready;
  logic        cons_req = 1'b0;
  logic        cons_ena;
  logic [13:0] wr_ptr;
  logic [13:0] rd_ptr;
  logic [14:0] occupancy;
  logic        empty;
  logic        full;
  logic [1:0]  state;
  logic        underrun;
  logic        proto_err;
  logic [31:0] underrun_cnt;
  logic [31:0] grant_cnt;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef SONIC_RING_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  sonic_ring_ctrl dut (
    .clk_in(clk_in), .reset(reset), .enable(enable), .flush(flush),
    .prod_valid(prod_valid), .prod_count(prod_count), .prod_ready(prod_ready),
    .cons_req(cons_req), .cons_ena(cons_ena), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
    .occupancy(occupancy), .empty(empty), .full(full), .state(state),
    .underrun(underrun), .proto_err(proto_err),
    .underrun_cnt(underrun_cnt), .grant_cnt(grant_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  // Present a burst, wait (bounded) for room, let it be taken on one edge.
  task automatic offer(input int n);
    int guard;
    guard = 0;
    prod_valid = 1'b1;
    prod_count = 10'(n);
    #1;
    while (!prod_ready && guard < 2000) begin
      cyc();
      guard++;
    end
    chk("offer_ready", {31'd0, prod_ready}, 32'd1);
    cyc();
    prod_valid = 1'b0;
    prod_count = 10'd0;
    #1;
  endtask

  initial begin
    int guard;

    // Reset values, with a consume request already pending.
    cons_req = 1'b1;
    cyc();
    cyc();
    chk("rst_wr", {18'd0, wr_ptr}, 0);
    chk("rst_rd", {18'd0, rd_ptr}, 0);
    chk("rst_occ", {17'd0, occupancy}, 0);
    chk("rst_empty", {31'd0, empty}, 1);
    chk("rst_full", {31'd0, full}, 0);
    chk("rst_state", {30'd0, state}, 0);
    chk("rst_ready", {31'd0, prod_ready}, 0);
    chk("rst_ena", {31'd0, cons_ena}, 0);
    chk("rst_flags", {30'd0, underrun, proto_err}, 0);
    chk("rst_cnts", grant_cnt | underrun_cnt, 0);
    reset = 1'b0;

    // Prefill: no grants until occupancy reaches the watermark.
    enable = 1'b1;
    cyc();
    chk("fill_state", {30'd0, state}, 1);
    chk("fill_ready", {31'd0, prod_ready}, 1);
    for (int i = 0; i < 5; i++) offer(100);
    chk("pre500_occ", {17'd0, occupancy}, 500);
    chk("pre500_ena", {31'd0, cons_ena}, 0);
    offer(12);
    chk("pre512_occ", {17'd0, occupancy}, 512);
    chk("pre512_state", {30'd0, state}, 1);
    chk("pre512_ena", {31'd0, cons_ena}, 0);
    cyc();
    chk("run_state", {30'd0, state}, 2);
    chk("run_ena", {31'd0, cons_ena}, 1);
    cons_req = 1'b0;
    #1;

    // Ready boundary at DEPTH-MAXB and full at DEPTH.
    for (int i = 0; i < 29; i++) offer(512);
    chk("b15360_occ", {17'd0, occupancy}, 15360);
    chk("b15360_ready", {31'd0, prod_ready}, 1);
    offer(512);
    chk("full_occ", {17'd0, occupancy}, 15872);
    chk("full_flag", {31'd0, full}, 1);
    chk("full_ready", {31'd0, prod_ready}, 0);
    chk("full_wr_wrap", {18'd0, wr_ptr}, 0);
    cons_req = 1'b1;
    cyc();
    cons_req = 1'b0;
    #1;
    chk("c1_occ", {17'd0, occupancy}, 15871);
    chk("c1_full", {31'd0, full}, 0);
    cons_req = 1'b1;
    repeat (510) cyc();
    cons_req = 1'b0;
    #1;
    chk("b15361_ready", {31'd0, prod_ready}, 0);
    chk("b15361_occ", {17'd0, occupancy}, 15361);
    cons_req = 1'b1;
    cyc();
    chk("b15360_ready2", {31'd0, prod_ready}, 1);
    chk("b15360_rd", {18'd0, rd_ptr}, 512);

    // Stream while consuming until wr_ptr sits at 0x3D00, then drain to an underrun.
    for (int i = 0; i < 30; i++) offer(512);
    offer(256);
    chk("stream_wr", {18'd0, wr_ptr}, 32'h3D00);
    guard = 0;
    while (occupancy != 15'd0 && guard < 40000) begin
      cyc();
      guard++;
    end
    chk("drain_occ", {17'd0, occupancy}, 0);
    chk("drain_rd", {18'd0, rd_ptr}, 32'h3D00);
    chk("drain_ena", {31'd0, cons_ena}, 0);
    chk("drain_pre_urun", {31'd0, underrun}, 0);
    cyc();
    chk("urun_state", {30'd0, state}, 1);
    chk("urun_flag", {31'd0, underrun}, 1);
    chk("urun_ena", {31'd0, cons_ena}, 0);
    chk("urun_cnt", underrun_cnt, STATS ? 32'd1 : 32'd0);
    cyc();
    chk("urun_cnt_hold", underrun_cnt, STATS ? 32'd1 : 32'd0);
    cons_req = 1'b0;
    #1;

    // Wrap: 512 deposited at 0x3D00, then 300 consumed.
    offer(512);
    chk("wrap_wr", {18'd0, wr_ptr}, 32'h0100);
    cyc();
    chk("wrap_state", {30'd0, state}, 2);
    cons_req = 1'b1;
    repeat (300) cyc();
    cons_req = 1'b0;
    #1;
    chk("wrap_rd", {18'd0, rd_ptr}, 32'h002C);
    chk("wrap_occ", {17'd0, occupancy}, 212);

    // Simultaneous accept and grant at occupancy 600.
    offer(388);
    chk("sim_pre_occ", {17'd0, occupancy}, 600);
    prod_valid = 1'b1;
    prod_count = 10'd10;
    cons_req = 1'b1;
    #1;
    chk("sim_ena", {31'd0, cons_ena}, 1);
    chk("sim_ready", {31'd0, prod_ready}, 1);
    cyc();
    prod_valid = 1'b0;
    cons_req = 1'b0;
    #1;
    chk("sim_occ", {17'd0, occupancy}, 609);
    chk("sim_wr", {18'd0, wr_ptr}, 654);
    chk("grant_total", grant_cnt, STATS ? 32'd31789 : 32'd0);

    // Oversized and zero-length bursts leave the pointers alone.
    offer(600);
    chk("perr_flag", {31'd0, proto_err}, 1);
    chk("perr_wr", {18'd0, wr_ptr}, 654);
    chk("perr_rd", {18'd0, rd_ptr}, 45);
    chk("perr_occ", {17'd0, occupancy}, 609);
    offer(0);
    chk("zero_occ", {17'd0, occupancy}, 609);

    // IDLE holds everything.
    enable = 1'b0;
    cyc();
    chk("idle_state", {30'd0, state}, 0);
    prod_valid = 1'b1;
    prod_count = 10'd10;
    cons_req = 1'b1;
    #1;
    chk("idle_ena", {31'd0, cons_ena}, 0);
    chk("idle_ready", {31'd0, prod_ready}, 0);
    cyc();
    chk("idle_occ", {17'd0, occupancy}, 609);
    enable = 1'b1;
    cyc();
    cyc();
    chk("resume_state", {30'd0, state}, 2);

    // Flush wins over a live offer and request.
    flush = 1'b1;
    #1;
    chk("flush_ena", {31'd0, cons_ena}, 0);
    chk("flush_ready", {31'd0, prod_ready}, 0);
    cyc();
    flush = 1'b0;
    prod_valid = 1'b0;
    cons_req = 1'b0;
    #1;
    chk("flush_wr", {18'd0, wr_ptr}, 0);
    chk("flush_rd", {18'd0, rd_ptr}, 0);
    chk("flush_occ", {17'd0, occupancy}, 0);
    chk("flush_state", {30'd0, state}, 0);
    chk("flush_flags", {30'd0, underrun, proto_err}, 0);
    chk("flush_cnts", grant_cnt | underrun_cnt, 0);
    chk("flush_empty", {31'd0, empty}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
